// File: rtl/lfsr_burst_arbiter_if.sv
// Bundle of request, reseed and data-stream signals for lfsr_burst_arbiter.
//
// Requester / consumer side (master modport drives these):
//   req         per-requester burst request, level
//   req_len     burst length of requester i in [i*LEN_W +: LEN_W]; 0 means 2^LEN_W words
//   reseed_req  request to load seed into the generator (hold until busy is seen)
//   seed        new generator state
//   data_ready  consumer accepts the current beat
// Arbiter side (slave modport drives these):
//   gnt         one-hot grant, held for the whole burst
//   data_out    current generator state, valid when data_valid
//   data_valid  beat valid
//   data_id     index of the granted requester
//   done        one-cycle pulse coincident with the accepted last beat
//   busy        high while bursting or reseeding
interface lfsr_burst_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned ID_W    = 2
);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic                     reseed_req;
  logic [48:0]              seed;
  logic                     data_ready;

  logic [NUM_REQ-1:0]       gnt;
  logic [48:0]              data_out;
  logic                     data_valid;
  logic [ID_W-1:0]          data_id;
  logic                     done;
  logic                     busy;

  modport master (
    output req,
    output req_len,
    output reseed_req,
    output seed,
    output data_ready,
    input  gnt,
    input  data_out,
    input  data_valid,
    input  data_id,
    input  done,
    input  busy
  );

  modport slave (
    input  req,
    input  req_len,
    input  reseed_req,
    input  seed,
    input  data_ready,
    output gnt,
    output data_out,
    output data_valid,
    output data_id,
    output done,
    output busy
  );

endinterface

// File: rtl/lfsr_burst_arbiter.sv
// Round-robin sharing of one 49-bit PRBS generator between NUM_REQ requesters.
// Each grant streams a burst of consecutive generator words over valid/ready; the
// generator only advances on accepted beats, so no word is lost or duplicated
// across requesters. Reseeding is sequenced between bursts.
//
// Ports:
//   clk      single clock, rising edge
//   reset_n  asynchronous active-low reset; aborts any burst/reseed without done
//   bus      lfsr_burst_arbiter_if.slave: requests, reseed, data stream, status
module lfsr_burst_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned ID_W       = 2,
  parameter logic [48:0] INIT_VALUE = 49'h1_55AA_AA55_55AA
) (
  input  logic                 clk,
  input  logic                 reset_n,
  lfsr_burst_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    StIdle,
    StReseed,
    StBurst
  } state_e;

  // All-ones is the lock-up state of the XNOR feedback; never load it.
  localparam logic [48:0]    LockUp  = {49{1'b1}};
  localparam logic [LEN_W:0] CntOne  = (LEN_W+1)'(1);
  localparam logic [LEN_W:0] CntFull = {1'b1, {LEN_W{1'b0}}};
  localparam logic [ID_W-1:0] LastIdx = ID_W'(NUM_REQ - 1);

  state_e               state_q, state_d;
  logic [48:0]          lfsr_q, lfsr_d;
  logic [LEN_W:0]       cnt_q, cnt_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;

  logic                 pick_valid;
  logic [ID_W-1:0]      pick_idx;
  logic [NUM_REQ-1:0]   pick_oh;
  logic [LEN_W-1:0]     pick_len;
  logic [LEN_W:0]       pick_cnt;
  logic [48:0]          lfsr_step;
  logic [48:0]          seed_safe;
  logic                 in_burst;
  logic                 accept;
  logic                 last_beat;

  // ---------------------------------------------------------------------------
  // Round-robin pick: first asserted request at or above the pointer, otherwise
  // the first asserted request from index 0 (the wrapped part of the search).
  // ---------------------------------------------------------------------------
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    pick_oh    = '0;
    pick_len   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!pick_valid && bus.req[i] && (ID_W'(i) >= ptr_q)) begin
        pick_valid = 1'b1;
        pick_idx   = ID_W'(i);
        pick_oh    = '0;
        pick_oh[i] = 1'b1;
        pick_len   = bus.req_len[i*LEN_W +: LEN_W];
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!pick_valid && bus.req[i]) begin
        pick_valid = 1'b1;
        pick_idx   = ID_W'(i);
        pick_oh    = '0;
        pick_oh[i] = 1'b1;
        pick_len   = bus.req_len[i*LEN_W +: LEN_W];
      end
    end
  end

  // A zero length field encodes the full 2^LEN_W burst.
  assign pick_cnt  = (pick_len == '0) ? CntFull : {1'b0, pick_len};

  assign lfsr_step = {lfsr_q[47:0], ~(lfsr_q[48] ^ lfsr_q[39])};
  assign seed_safe = (bus.seed == LockUp) ? INIT_VALUE : bus.seed;

  assign in_burst  = (state_q == StBurst);
  assign accept    = in_burst && bus.data_ready;
  assign last_beat = accept && (cnt_q == CntOne);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    gnt_d   = gnt_q;

    case (state_q)
      StIdle: begin
        if (bus.reseed_req) begin
          state_d = StReseed;
        end else if (pick_valid) begin
          state_d = StBurst;
          gnt_d   = pick_oh;
          id_d    = pick_idx;
          cnt_d   = pick_cnt;
          ptr_d   = (pick_idx == LastIdx) ? '0 : pick_idx + 1'b1;
        end
      end

      StReseed: begin
        lfsr_d  = seed_safe;
        state_d = StIdle;
      end

      StBurst: begin
        if (accept) begin
          lfsr_d = lfsr_step;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == CntOne) begin
            gnt_d   = '0;
            state_d = StIdle;
          end
        end
      end

      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      lfsr_q  <= INIT_VALUE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      id_q    <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      gnt_q   <= gnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: data and id are forced to zero outside a burst so the stream is
  // quiet while idle, reseeding or in reset.
  // ---------------------------------------------------------------------------
  assign bus.gnt        = gnt_q;
  assign bus.data_valid = in_burst;
  assign bus.data_out   = in_burst ? lfsr_q : '0;
  assign bus.data_id    = in_burst ? id_q : '0;
  assign bus.done       = last_beat;
  assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_lfsr_burst_arbiter.sv
// Randomised scoreboard bench for lfsr_burst_arbiter. Stimulus tasks predict each
// burst from a behavioural model (modular round-robin search, word list from the
// PRBS recurrence) and push expected beats; a negedge monitor pops and compares
// every accepted beat.
module tb_lfsr_burst_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned LW = 8;
  localparam int unsigned IW = 2;
  localparam logic [48:0] INIT = 49'h1_55AA_AA55_55AA;

  typedef struct packed {
    logic [48:0]   data;
    logic [IW-1:0] id;
    logic [N-1:0]  gnt;
    logic          done;
  } beat_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  lfsr_burst_arbiter_if #(.NUM_REQ(N), .LEN_W(LW), .ID_W(IW)) bus ();

  lfsr_burst_arbiter #(
    .NUM_REQ   (N),
    .LEN_W     (LW),
    .ID_W      (IW),
    .INIT_VALUE(INIT)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  beat_t       exp_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [48:0] m_lfsr;
  int          m_ptr;
  bit          pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endfunction

  function automatic logic [48:0] step(input logic [48:0] s);
    return {s[47:0], ~(s[48] ^ s[39])};
  endfunction

  // Model round robin: first set bit scanning upward from the pointer, modulo N.
  function automatic int pick(input logic [N-1:0] m);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (m_ptr + k) % N;
      if (m[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic ready_val(input int mode, input int idx);
    if (mode == 1) return ($urandom_range(0, 3) != 0);
    if (mode == 2 && idx < 7) return pat[idx];
    return 1'b1;
  endfunction

  // Monitor: compare every accepted beat against the scoreboard head.
  always @(negedge clk) begin
    beat_t e;
    if (reset_n === 1'b1 && bus.data_valid === 1'b1 && bus.data_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_beat: got data %h id %0d, expected no beat",
                 bus.data_out, bus.data_id);
      end else begin
        e = exp_q.pop_front();
        check("beat", 64'({bus.data_out, bus.data_id, bus.gnt, bus.done}), 64'(e));
      end
    end
  end

  // One burst: predict, request, drive ready per mode, optionally reset at a beat.
  task automatic burst(input logic [N-1:0] mask, input logic [N*LW-1:0] lens,
                       input int rmode, input int abort_at);
    int            idx, len, beats;
    bit            got_done, aborted, prev_stall;
    logic [48:0]   prev_d;
    logic [IW-1:0] prev_id;
    logic [N-1:0]  prev_g, oh;
    beat_t         b;

    idx = pick(mask);
    len = int'(lens[idx*LW +: LW]);
    if (len == 0) len = 1 << LW;
    oh = '0;
    oh[idx] = 1'b1;
    for (int k = 0; k < len; k++) begin
      b = '{data: m_lfsr, id: IW'(idx), gnt: oh, done: (k == len - 1)};
      exp_q.push_back(b);
      m_lfsr = step(m_lfsr);
    end
    m_ptr = (idx + 1) % N;

    @(posedge clk); #1;
    bus.req     = mask;
    bus.req_len = lens;
    beats = 0; got_done = 0; aborted = 0; prev_stall = 0;
    prev_d = '0; prev_id = '0; prev_g = '0;
    for (int c = 0; c < len * 6 + 20; c++) begin
      @(posedge clk); #1;
      bus.req        = '0;
      bus.data_ready = ready_val(rmode, c);
      @(negedge clk);
      if (c == 0) check("grant_latency", 64'(bus.gnt), 64'(oh));
      if (prev_stall)
        check("hold_stable", 64'({bus.data_out, bus.data_id, bus.gnt}),
              64'({prev_d, prev_id, prev_g}));
      prev_stall = bus.data_valid && !bus.data_ready;
      prev_d = bus.data_out; prev_id = bus.data_id; prev_g = bus.gnt;
      if (bus.data_valid && bus.data_ready) beats++;
      if (bus.done) begin
        got_done = 1;
        break;
      end
      if (abort_at > 0 && beats == abort_at) begin
        #2 reset_n = 1'b0;
        #1 check("async_reset", 64'({bus.gnt, bus.data_valid, bus.data_out, bus.data_id,
                                     bus.done, bus.busy}), 64'(0));
        exp_q.delete();
        m_lfsr = INIT;
        m_ptr  = 0;
        repeat (2) @(negedge clk);
        check("reset_no_done", 64'({bus.done, bus.busy}), 64'(0));
        reset_n = 1'b1;
        aborted = 1;
        break;
      end
    end
    bus.data_ready = 1'b1;
    if (!aborted) begin
      if (!got_done) begin
        n_cmp++;
        n_fail++;
        $display("FAIL burst_timeout: got %0d beats without done, expected %0d", beats, len);
      end else begin
        check("beat_count", 64'(beats), 64'(len));
        @(posedge clk); #1;
        @(negedge clk);
        check("post_done_idle", 64'({bus.gnt, bus.data_valid, bus.done}), 64'(0));
      end
    end
  endtask

  // Requests held on every line with length 1: grants rotate with one idle gap.
  task automatic held_rr(input int nb);
    int           cyc[$];
    int           dones, idx;
    logic [N-1:0] oh;
    beat_t        b;
    for (int k = 0; k < nb; k++) begin
      idx = m_ptr;
      oh = '0;
      oh[idx] = 1'b1;
      b = '{data: m_lfsr, id: IW'(idx), gnt: oh, done: 1'b1};
      exp_q.push_back(b);
      m_lfsr = step(m_lfsr);
      m_ptr  = (m_ptr + 1) % N;
    end
    @(posedge clk); #1;
    bus.req = '1;
    for (int i = 0; i < N; i++) bus.req_len[i*LW +: LW] = LW'(1);
    bus.data_ready = 1'b1;
    dones = 0;
    for (int c = 0; c < nb * 4 + 10; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (bus.done) begin
        cyc.push_back(c);
        dones++;
        if (dones == nb) break;
      end
    end
    @(posedge clk); #1;
    bus.req = '0;
    check("rr_done_count", 64'(dones), 64'(nb));
    for (int k = 1; k < cyc.size(); k++)
      check("rr_spacing", 64'(cyc[k] - cyc[k-1]), 64'(2));
    @(posedge clk); #1;
    @(negedge clk);
    check("rr_release", 64'({bus.gnt, bus.data_valid}), 64'(0));
  endtask

  // Reseed, optionally with requests pending to show reseed wins.
  task automatic reseed(input logic [48:0] s, input logic [N-1:0] mask);
    @(posedge clk); #1;
    bus.reseed_req = 1'b1;
    bus.seed       = s;
    bus.req        = mask;
    @(posedge clk); #1;
    @(negedge clk);
    check("reseed_busy", 64'({bus.busy, bus.data_valid, bus.gnt}), 64'({1'b1, 1'b0, {N{1'b0}}}));
    @(posedge clk); #1;
    bus.reseed_req = 1'b0;
    bus.req        = '0;
    @(negedge clk);
    check("reseed_done", 64'({bus.busy, bus.gnt}), 64'(0));
    m_lfsr = (s == {49{1'b1}}) ? INIT : s;
  endtask

  function automatic logic [N*LW-1:0] one_len(input int slot, input int len);
    logic [N*LW-1:0] v;
    v = '0;
    v[slot*LW +: LW] = LW'(len);
    return v;
  endfunction

  initial begin
    logic [63:0]     r;
    logic [48:0]     s;
    logic [N-1:0]    mask;
    logic [N*LW-1:0] lens;

    reset_n        = 1'b0;
    bus.req        = '0;
    bus.req_len    = '0;
    bus.reseed_req = 1'b0;
    bus.seed       = '0;
    bus.data_ready = 1'b1;
    m_lfsr         = INIT;
    m_ptr          = 0;
    repeat (3) @(negedge clk);
    check("reset_state", 64'({bus.gnt, bus.data_valid, bus.data_out, bus.data_id,
                              bus.done, bus.busy}), 64'(0));
    reset_n = 1'b1;

    burst(4'b0001, one_len(0, 3), 0, 0);
    held_rr(5);
    burst(4'b0010, one_len(1, 4), 2, 0);
    reseed(49'h0_0000_0000_0001, '0);
    burst(4'b0100, one_len(2, 2), 0, 0);
    reseed({49{1'b1}}, 4'b1000);
    burst(4'b1000, one_len(3, 1), 0, 0);
    burst(4'b0001, '0, 0, 0);
    burst(4'b0100, '0, 0, 100);
    held_rr(5);

    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        r = {$urandom, $urandom};
        s = (t % 2 == 0) ? r[48:0] : {49{1'b1}};
        reseed(s, 4'($urandom_range(0, 15)));
      end
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) lens[i*LW +: LW] = LW'($urandom_range(1, 10));
      burst(mask, lens, int'($urandom_range(0, 2)), 0);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_burst_arbiter.md
Name: lfsr_burst_arbiter

Overview:
- Shares one 49-bit PRBS generator between NUM_REQ requesters, on a round-robin basis.
- Each grant delivers a burst of consecutive LFSR words over a valid/ready stream.
- The block owns the LFSR state and advances it only on accepted beats, so no sequence word is lost or duplicated across requesters.
- Also sequences reseeding of the generator between bursts.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LEN_W, 8, width of each per-requester burst-length field.
- ID_W, 2, width of DATA_ID; must satisfy 2^ID_W >= NUM_REQ.
- INIT_VALUE, 49'h1_55AA_AA55_55AA, LFSR state after reset; also the substitute for an illegal seed.

Ports:
- CLK  in  1  single clock; all logic on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- REQ  in  NUM_REQ  per-requester burst request, level.
- REQ_LEN  in  NUM_REQ*LEN_W  burst length of requester i in slice [i*LEN_W +: LEN_W]; 0 means 2^LEN_W words.
- RESEED_REQ  in  1  request to load SEED into the LFSR.
- SEED  in  49  new LFSR state.
- DATA_READY  in  1  consumer accepts the current beat.
- GNT  out  NUM_REQ  one-hot grant, held for the whole burst.
- DATA_OUT  out  49  current LFSR state, valid when DATA_VALID.
- DATA_VALID  out  1  beat valid.
- DATA_ID  out  ID_W  index of the granted requester.
- DONE  out  1  one-cycle pulse, coincident with the accepted last beat.
- BUSY  out  1  high in BURST or RESEED.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - LFSR = INIT_VALUE; state = IDLE; round-robin pointer = 0.
  - GNT = 0, DATA_VALID = 0, DATA_OUT = 0, DATA_ID = 0, DONE = 0, BUSY = 0.
  - A reset mid-burst or mid-reseed aborts immediately; no DONE is issued.
- LFSR step: next = {s[47:0], s[48] XNOR s[39]}.
  - The all-ones state is the lock-up state.
  - The LFSR steps only on a beat where DATA_VALID & DATA_READY are both high.
- FSM states: IDLE, RESEED, BURST.
- IDLE:
  - If RESEED_REQ is high, go to RESEED. Reseed has priority over REQ.
  - Else, if any REQ bit is high, pick the first asserted index searching from the pointer upward with wrap.
  - On that edge register: GNT (one-hot), DATA_ID, the burst count from the REQ_LEN slice (0 maps to 2^LEN_W), and pointer = granted index + 1 mod NUM_REQ. Then go to BURST.
- Grant timing: a REQ sampled in IDLE at edge t gives GNT, DATA_VALID and the first word at t+1.
- RESEED (one cycle):
  - LFSR = SEED, or INIT_VALUE if SEED == 49'h1_FFFF_FFFF_FFFF.
  - Return to IDLE. BUSY is high for this cycle.
- BURST:
  - DATA_VALID = 1; DATA_OUT tracks the LFSR state.
  - On each accepted beat: count decrements and the LFSR steps.
  - While DATA_READY is low, DATA_OUT, DATA_ID and GNT are held stable (standard valid/ready; VALID never drops mid-burst).
  - Accepted beat with count == 1: DONE = 1 in that same cycle. On the next edge GNT = 0, DATA_VALID = 0, state = IDLE.
- Throughput: one word per cycle with DATA_READY high.
  - A minimum of one IDLE cycle separates consecutive bursts.
- Ignored inputs:
  - REQ or REQ_LEN changes during BURST are ignored; the burst always completes.
  - RESEED_REQ outside IDLE is ignored. The requester must hold it until BUSY is seen high.
- Fairness: a requester that keeps REQ high waits at most NUM_REQ-1 bursts.
- Counter widths:
  - The count register is LEN_W+1 bits, so it can hold 2^LEN_W.
  - No arithmetic wrap is permitted.

Test Plan:
- Reset, then REQ=4'b0001 with REQ_LEN[7:0]=3, DATA_READY=1:
  - GNT=0001 one cycle after the request.
  - Words 49'h1_55AA_AA55_55AA, then 49'h0_AB55_54AA_AB55, then the next step.
  - DONE on the third beat; GNT=0 on the following cycle.
- REQ=4'b1111 held, all lengths 1: grants in order 0,1,2,3,0 with DATA_ID 0,1,2,3,0 and one IDLE cycle between bursts.
- Backpressure, length 4 burst, DATA_READY toggled 1,0,0,1,1,0,1:
  - DATA_OUT and DATA_ID stable while READY=0.
  - Exactly 4 distinct consecutive LFSR words are accepted; DONE on the 4th accepted beat.
- RESEED_REQ with SEED=49'h0_0000_0000_0001, then a length 2 burst: first word 49'h0_0000_0000_0001, second word 49'h0_0000_0000_0003.
- RESEED_REQ with SEED = all ones, then a length 1 burst: the word is 49'h1_55AA_AA55_55AA.
- Mid-burst events:
  - REQ_LEN=0 burst: 256 beats, DONE only on the 256th.
  - RESET_N pulsed low at beat 100 of a second such burst: all outputs 0 asynchronously, no DONE, next burst starts from INIT_VALUE with a grant to index 0.
